// File: rtl/program_counter.sv
// program_counter: architectural PC register; loads load_val every cycle, synchronous reset to RESET_VAL
module program_counter #(
  parameter int WIDTH = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] pc
);
  logic [WIDTH-1:0] pc_q, pc_d;
  always_comb pc_d = rst ? RESET_VAL : load_val;
  always_ff @(posedge clk) pc_q <= pc_d;
  assign pc = pc_q;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: randomized and directed checks of the PC register against a reference model
module tb_program_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] load_val = 5'b11110;
  logic [4:0] pc;
  logic [4:0] exp_pc;
  int checks = 0;
  int errors = 0;

  program_counter #(.WIDTH(5), .RESET_VAL(5'd0)) dut (
    .clk(clk), .rst(rst), .load_val(load_val), .pc(pc)
  );

  always #5 clk = ~clk;

  // Drive inputs, take one rising edge, update the model, settle 1 unit past the edge.
  task automatic cycle(input logic r, input logic [4:0] v);
    rst = r;
    load_val = v;
    @(posedge clk);
    exp_pc = r ? 5'd0 : v;
    #1;
  endtask

  task automatic test_reset;
    cycle(1'b1, 5'b11110);
    checks++;
    if (pc !== 5'b00000) begin errors++; $display("FAIL reset_entry pc=%b exp=%b", pc, 5'b00000); end
    cycle(1'b1, 5'b10101);
    checks++;
    if (pc !== 5'b00000) begin errors++; $display("FAIL reset_hold pc=%b exp=%b", pc, 5'b00000); end
  endtask

  task automatic test_release;
    cycle(1'b0, 5'b11110);
    checks++;
    if (pc !== 5'b11110) begin errors++; $display("FAIL release_load pc=%b exp=%b", pc, 5'b11110); end
  endtask

  task automatic test_back_to_back;
    cycle(1'b0, 5'b00001);
    checks++;
    if (pc !== 5'b00001) begin errors++; $display("FAIL b2b_first pc=%b exp=%b", pc, 5'b00001); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 5'b00110);
      checks++;
      if (pc !== 5'b00110) begin errors++; $display("FAIL b2b_hold%0d pc=%b exp=%b", i, pc, 5'b00110); end
    end
  endtask

  task automatic test_mid_reset;
    cycle(1'b1, 5'b00110);
    checks++;
    if (pc !== 5'b00000) begin errors++; $display("FAIL mid_reset pc=%b exp=%b", pc, 5'b00000); end
    cycle(1'b1, 5'b00110);
    checks++;
    if (pc !== 5'b00000) begin errors++; $display("FAIL mid_reset_hold pc=%b exp=%b", pc, 5'b00000); end
  endtask

  task automatic test_boundary;
    cycle(1'b0, 5'b11111);
    checks++;
    if (pc !== 5'b11111) begin errors++; $display("FAIL boundary_ones pc=%b exp=%b", pc, 5'b11111); end
    cycle(1'b0, 5'b00000);
    checks++;
    if (pc !== 5'b00000) begin errors++; $display("FAIL boundary_zero pc=%b exp=%b", pc, 5'b00000); end
    cycle(1'b0, 5'b10000);
    checks++;
    if (pc !== 5'b10000) begin errors++; $display("FAIL boundary_msb pc=%b exp=%b", pc, 5'b10000); end
  endtask

  task automatic test_mid_cycle;
    cycle(1'b0, 5'b01011);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    checks++;
    if (pc !== 5'b01011) begin errors++; $display("FAIL pulse_between pc=%b exp=%b", pc, 5'b01011); end
    cycle(1'b0, 5'b01011);
    checks++;
    if (pc !== 5'b01011) begin errors++; $display("FAIL pulse_after_edge pc=%b exp=%b", pc, 5'b01011); end
    load_val = 5'b10100;
    #2;
    checks++;
    if (pc !== 5'b01011) begin errors++; $display("FAIL load_mid_cycle pc=%b exp=%b", pc, 5'b01011); end
    @(posedge clk);
    #1;
    checks++;
    if (pc !== 5'b10100) begin errors++; $display("FAIL load_next_edge pc=%b exp=%b", pc, 5'b10100); end
  endtask

  task automatic test_random;
    logic       r;
    logic [4:0] v;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 7) == 0);
      v = 5'($urandom);
      cycle(r, v);
      checks++;
      if (pc !== exp_pc) begin errors++; $display("FAIL random%0d rst=%b load=%b pc=%b exp=%b", i, r, v, pc, exp_pc); end
    end
  endtask

  initial begin
    test_reset;
    test_release;
    test_back_to_back;
    test_mid_reset;
    test_release;
    test_boundary;
    test_mid_cycle;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
